// File: rtl/score_counter.sv
// Purpose: game score FSM (IDLE/PLAY/OVER) with tap/hold scoring, saturation and high-score tracking.
// Latency: every output is registered and reflects inputs sampled one i_clk edge earlier.
// Backpressure: none; inputs are pulses or levels and are consumed in the cycle they are seen.
module score_counter #(
  parameter int HOLD_FRAMES = 8,
  parameter int MAX_SCORE   = 99
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_tick,
  input  logic       i_move,
  input  logic       i_collision,
  input  logic       i_start,
  output logic [6:0] o_score,
  output logic [6:0] o_high_score,
  output logic       o_playing,
  output logic       o_game_over,
  output logic       o_new_high
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [6:0] SCORE_MAX = 7'(MAX_SCORE);
  // The counter counts held ticks after the press; when it already sits at
  // the last value the next held tick scores, giving one point per HOLD_FRAMES.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_FRAMES - 1);

  state_t     state;
  logic [3:0] hold_cnt;
  logic       move_prev;
  logic       inc_req;

  // A scoring event on this frame tick: fresh press, or hold period elapsed.
  always_comb begin
    inc_req = 1'b0;
    if (i_frame_tick && i_move) begin
      inc_req = !move_prev || (hold_cnt == HOLD_LAST);
    end
  end

  // Game FSM with all outputs registered; collision outranks start and scoring.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      o_score      <= 7'd0;
      o_high_score <= 7'd0;
      o_playing    <= 1'b0;
      o_game_over  <= 1'b0;
      o_new_high   <= 1'b0;
      hold_cnt     <= 4'd0;
      move_prev    <= 1'b0;
    end else begin
      o_new_high <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (i_start) begin
            state       <= PLAY;
            o_playing   <= 1'b1;
            o_game_over <= 1'b0;
            o_score     <= 7'd0;
            hold_cnt    <= 4'd0;
            move_prev   <= 1'b0;
          end
        end
        PLAY: begin
          if (i_collision) begin
            state       <= OVER;
            o_playing   <= 1'b0;
            o_game_over <= 1'b1;
            if (o_score > o_high_score) begin
              o_high_score <= o_score;
              o_new_high   <= 1'b1;
            end
          end else if (i_frame_tick) begin
            move_prev <= i_move;
            if (!i_move) begin
              hold_cnt <= 4'd0;
            end else if (inc_req) begin
              hold_cnt <= 4'd0;
              if (o_score < SCORE_MAX) begin
                o_score <= o_score + 7'd1;
              end
            end else begin
              hold_cnt <= hold_cnt + 4'd1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          o_playing   <= 1'b0;
          o_game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_counter.sv
// Purpose: directed scoreboard bench for score_counter.
// Latency: expectations are queued right after an edge and checked at the following falling edge.
// Backpressure: none; the monitor drains every queued expectation each cycle.
module tb_score_counter;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_frame_tick;
  logic       i_move;
  logic       i_collision;
  logic       i_start;
  logic [6:0] o_score;
  logic [6:0] o_high_score;
  logic       o_playing;
  logic       o_game_over;
  logic       o_new_high;

  typedef struct packed {
    logic [6:0] score;
    logic [6:0] high;
    logic       playing;
    logic       over;
    logic       new_high;
  } exp_t;

  exp_t       exp_q[$];
  string      nm_q[$];
  logic [6:0] nh_q[$];
  int         checks;
  int         failures;
  logic       done;

  score_counter #(
    .HOLD_FRAMES(8),
    .MAX_SCORE  (99)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_frame_tick(i_frame_tick),
    .i_move      (i_move),
    .i_collision (i_collision),
    .i_start     (i_start),
    .o_score     (o_score),
    .o_high_score(o_high_score),
    .o_playing   (o_playing),
    .o_game_over (o_game_over),
    .o_new_high  (o_new_high)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Monitor: checks new-high pulses, drains expected output vectors, then summarises.
  initial begin
    exp_t  e;
    string nm;
    logic [6:0] nh;
    checks   = 0;
    failures = 0;
    forever begin
      @(negedge i_clk);
      if (o_new_high) begin
        checks++;
        if (nh_q.size() == 0) begin
          failures++;
          $display("FAIL new_high_unexpected: got pulse with high=%0d, required no pulse", o_high_score);
        end else begin
          nh = nh_q.pop_front();
          if (o_high_score !== nh) begin
            failures++;
            $display("FAIL new_high_value: got high=%0d, required high=%0d", o_high_score, nh);
          end
        end
      end
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        checks++;
        if ({o_score, o_high_score, o_playing, o_game_over, o_new_high} !== e) begin
          failures++;
          $display("FAIL %s: got score=%0d high=%0d playing=%0b over=%0b new_high=%0b, required score=%0d high=%0d playing=%0b over=%0b new_high=%0b",
                   nm, o_score, o_high_score, o_playing, o_game_over, o_new_high,
                   e.score, e.high, e.playing, e.over, e.new_high);
        end
      end
      if (done) begin
        checks++;
        if (nh_q.size() != 0) begin
          failures++;
          $display("FAIL new_high_missing: got %0d pulses short, required 0", nh_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [6:0] sc, input logic [6:0] hi,
                            input logic pl, input logic ov, input logic nh);
    exp_t e;
    e = '{score: sc, high: hi, playing: pl, over: ov, new_high: nh};
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic expect_nh(input string nm, input logic [6:0] sc, input logic [6:0] hi);
    nh_q.push_back(hi);
    expect_out(nm, sc, hi, 1'b0, 1'b1, 1'b1);
  endtask

  // Two idle cycles with the previous move level inverted (must be ignored), then one tick.
  task automatic frame(input logic mv);
    step();
    step();
    i_frame_tick = 1'b1;
    i_move       = mv;
    step();
    i_frame_tick = 1'b0;
    i_move       = ~mv;
  endtask

  task automatic tap();
    frame(1'b1);
    frame(1'b0);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic pulse_coll();
    i_collision = 1'b1;
    step();
    i_collision = 1'b0;
  endtask

  // Stimulus: directed sequence with hand-computed expectations.
  initial begin
    int hold_tick[5];
    int hold_exp[5];
    hold_tick = '{1, 8, 9, 16, 17};
    hold_exp  = '{1, 1, 2, 2, 3};
    done         = 1'b0;
    i_rst_n      = 1'b0;
    i_frame_tick = 1'b0;
    i_move       = 1'b1;
    i_collision  = 1'b0;
    i_start      = 1'b1;
    step();
    step();
    expect_out("reset", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    i_start = 1'b0;
    i_rst_n = 1'b1;

    frame(1'b1);
    expect_out("idle_move", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    pulse_coll();
    expect_out("idle_coll", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    pulse_start();
    expect_out("start", 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);

    tap();
    expect_out("tap1", 7'd1, 7'd0, 1'b1, 1'b0, 1'b0);
    tap();
    tap();
    expect_out("taps3", 7'd3, 7'd0, 1'b1, 1'b0, 1'b0);
    pulse_start();
    expect_out("start_in_play", 7'd3, 7'd0, 1'b1, 1'b0, 1'b0);
    tap();
    tap();
    expect_out("score5", 7'd5, 7'd0, 1'b1, 1'b0, 1'b0);

    pulse_coll();
    expect_nh("coll_new_high", 7'd5, 7'd5);
    step();
    expect_out("new_high_1cyc", 7'd5, 7'd5, 1'b0, 1'b1, 1'b0);
    frame(1'b1);
    expect_out("over_frozen", 7'd5, 7'd5, 1'b0, 1'b1, 1'b0);

    pulse_start();
    expect_out("restart", 7'd0, 7'd5, 1'b1, 1'b0, 1'b0);
    tap();
    tap();
    tap();
    pulse_coll();
    expect_out("coll_no_high", 7'd3, 7'd5, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("over_hold", 7'd3, 7'd5, 1'b0, 1'b1, 1'b0);

    pulse_start();
    frame(1'b0);
    for (int i = 1; i <= 17; i++) begin
      frame(1'b1);
      for (int k = 0; k < 5; k++) begin
        if (hold_tick[k] == i) begin
          expect_out($sformatf("hold_tick%0d", i), 7'(hold_exp[k]), 7'd5, 1'b1, 1'b0, 1'b0);
        end
      end
    end
    frame(1'b0);
    expect_out("hold_release", 7'd3, 7'd5, 1'b1, 1'b0, 1'b0);
    tap();
    expect_out("score4", 7'd4, 7'd5, 1'b1, 1'b0, 1'b0);

    step();
    step();
    i_frame_tick = 1'b1;
    i_move       = 1'b1;
    i_collision  = 1'b1;
    step();
    i_frame_tick = 1'b0;
    i_collision  = 1'b0;
    i_move       = 1'b0;
    expect_out("coll_vs_press", 7'd4, 7'd5, 1'b0, 1'b1, 1'b0);

    pulse_start();
    i_start     = 1'b1;
    i_collision = 1'b1;
    step();
    i_start     = 1'b0;
    i_collision = 1'b0;
    expect_out("start_coll_play", 7'd0, 7'd5, 1'b0, 1'b1, 1'b0);
    pulse_coll();
    expect_out("over_coll", 7'd0, 7'd5, 1'b0, 1'b1, 1'b0);

    pulse_start();
    for (int i = 0; i < 98; i++) tap();
    expect_out("score98", 7'd98, 7'd5, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      frame(1'b1);
      if (i == 1 || i == 9 || i == 30) begin
        expect_out($sformatf("sat_tick%0d", i), 7'd99, 7'd5, 1'b1, 1'b0, 1'b0);
      end
    end
    pulse_coll();
    expect_nh("coll_99", 7'd99, 7'd99);

    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
    expect_out("reset_clears_high", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);

    pulse_start();
    for (int i = 0; i < 12; i++) tap();
    pulse_coll();
    expect_nh("high12", 7'd12, 7'd12);
    pulse_start();
    for (int i = 0; i < 6; i++) tap();
    frame(1'b1);
    expect_out("pre_rst7", 7'd7, 7'd12, 1'b1, 1'b0, 1'b0);
    frame(1'b1);
    i_move  = 1'b1;
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
    expect_out("reset_mid", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    frame(1'b1);
    frame(1'b1);
    expect_out("no_count_idle", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    pulse_start();
    expect_out("start_after_rst", 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
    frame(1'b1);
    expect_out("count_after_start", 7'd1, 7'd0, 1'b1, 1'b0, 1'b0);

    step();
    done = 1'b1;
    step();
    step();
  end

endmodule

// File: doc/score_counter.md
SCORE_COUNTER -- requirements
Module: score_counter

Interface
REQ-001 Parameter HOLD_FRAMES, default 8, frame ticks between repeat increments while move is held (legal range 2..15).
REQ-002 Parameter MAX_SCORE, default 99, saturation value of o_score (two displayed digits).
REQ-003 i_clk  input  1  system/pixel clock.
REQ-004 i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_frame_tick  input  1  one-cycle pulse per video frame (start of vertical blank).
REQ-006 i_move  input  1  move button level, already synchronised to i_clk.
REQ-007 i_collision  input  1  one-cycle pulse, player hit an obstacle.
REQ-008 i_start  input  1  one-cycle pulse, start a new game.
REQ-009 o_score  output  7  current score, binary, 0..MAX_SCORE.
REQ-010 o_high_score  output  7  best score since reset, binary.
REQ-011 o_playing  output  1  high while state is PLAY.
REQ-012 o_game_over  output  1  high while state is OVER.
REQ-013 o_new_high  output  1  one-cycle pulse when o_high_score is updated.

Function
REQ-014 The block SHALL implement states IDLE, PLAY, OVER; all outputs SHALL be registered.
REQ-015 IDLE -> PLAY on i_start; OVER -> PLAY on i_start; PLAY -> OVER on i_collision; all other inputs SHALL hold state.
REQ-016 i_start in PLAY SHALL be ignored.
REQ-017 Entry to PLAY SHALL clear o_score, the hold counter and the move-history bit in the same cycle as the state change.
REQ-018 o_score SHALL change only in a cycle with i_frame_tick high in PLAY, so that o_score is stable for a whole frame.
REQ-019 On i_frame_tick in PLAY, with i_move=1 and i_move at the previous frame tick 0 (press), o_score SHALL increment by 1 and the hold counter SHALL become 0.
REQ-020 On i_frame_tick in PLAY, with i_move=1 at this and the previous tick (held), the hold counter SHALL increment; when it reaches HOLD_FRAMES-1, o_score SHALL increment by 1 and the counter SHALL become 0.
REQ-021 On i_frame_tick with i_move=0, the hold counter SHALL become 0 and o_score SHALL be unchanged.
REQ-022 The move-history bit SHALL update only on i_frame_tick; i_move between ticks SHALL be ignored.
REQ-023 Increments SHALL saturate: at o_score == MAX_SCORE, o_score SHALL stay at MAX_SCORE and SHALL never wrap.
REQ-024 Collision priority: i_collision and an increment in the same cycle SHALL give OVER with o_score unchanged.
REQ-025 On the PLAY -> OVER transition, if o_score > o_high_score, o_high_score SHALL take o_score and o_new_high SHALL pulse for exactly 1 cycle, both 1 cycle after i_collision.
REQ-026 If o_score <= o_high_score, o_high_score SHALL stay unchanged and o_new_high SHALL stay 0.
REQ-027 In OVER, o_score SHALL stay frozen until i_start.
REQ-028 i_collision outside PLAY SHALL be ignored.
REQ-029 i_start and i_collision in the same PLAY cycle SHALL be handled as a collision only.

Reset
REQ-030 With i_rst_n=0 at a clock edge: state IDLE, o_score=0, o_high_score=0, o_playing=0, o_game_over=0, o_new_high=0, hold counter=0, move-history=0.
REQ-031 Reset SHALL take priority over every other input, including mid-game and mid-hold.
REQ-032 Reset SHALL clear o_high_score.

Verification
REQ-033 Reset, i_start, then 3 separate taps (i_move high for 1 tick, low for 1 tick) -> o_score=3; o_playing=1.
REQ-034 HOLD_FRAMES=8, i_move held for 17 frame ticks from released -> increments at ticks 1, 9, 17; o_score=3.
REQ-035 Preload score to 98 and hold i_move for 30 ticks -> o_score reaches 99 and stays 99.
REQ-036 Score 5, collision, then start and reach score 3, collision -> first collision: o_high_score=5 with a 1-cycle o_new_high; second: o_high_score stays 5 and o_new_high=0; o_game_over=1 and o_score=3 frozen.
REQ-037 i_collision and a press increment on the same i_frame_tick at score 4 -> OVER, o_score=4.
REQ-038 i_rst_n low for 1 cycle during PLAY at score 7, high score 12 -> all outputs 0, state IDLE; a later i_start is required before the score counts.
